// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/load-store RAM arbiter: access sizes, RAM op,
// response-register layout and the default RAM word-address width.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_W = 10;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_e;

    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } mem_op_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // size is kept raw so an illegal encoding can still be carried to the response
    typedef struct packed {
        owner_e      owner;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] wdata;
        logic        err;
    } rsp_reg_t;

endpackage

// File: rtl/mem_lane_merge.sv
// Byte-lane helper: merges sub-word store data into the old RAM word and
// extracts/extends sub-word load results. Purely combinational.
module mem_lane_merge
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_merged,
    output logic [31:0] o_load
);
    logic [4:0]  w_bsh;
    logic [4:0]  w_hsh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_bsh  = {i_off, 3'b000};
    assign w_hsh  = {i_off[1], 4'b0000};
    assign w_byte = 8'(i_rdata >> w_bsh);
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Lane selection per access size; illegal sizes never reach the RAM.
    always_comb begin
        case (i_size)
            BYTE: begin
                o_load   = {{24{w_byte[7] & ~i_uns}}, w_byte};
                o_merged = (i_rdata & ~(32'h0000_00FF << w_bsh))
                         | ({24'h00_0000, i_wdata[7:0]} << w_bsh);
            end
            HALF: begin
                o_load   = {{16{w_half[15] & ~i_uns}}, w_half};
                o_merged = (i_rdata & ~(32'h0000_FFFF << w_hsh))
                         | ({16'h0000, i_wdata[15:0]} << w_hsh);
            end
            default: begin
                o_load   = i_rdata;
                o_merged = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port word RAM between instruction fetch and
// load/store, with a 2-stage issue/response pipeline and sub-word support.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int MAX_DSTREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output mem_op_e     ram_mem_op,
    input  logic [31:0] ram_rdata
);
    logic [3:0]  r_streak;
    logic        r_valid;
    rsp_reg_t    r_rsp;

    logic        w_fetch_turn;
    logic        w_if_gnt;
    logic        w_d_gnt;
    logic        w_if_err;
    logic        w_d_mis;
    logic        w_d_err;
    logic        w_live;
    logic        w_store;
    logic [31:0] w_merged;
    logic [31:0] w_load;

    // Fetch only overtakes data once the data streak has hit its limit.
    assign w_fetch_turn = if_req && (r_streak == 4'(MAX_DSTREAK));
    assign w_d_gnt      = !rst && d_req && !w_fetch_turn;
    assign w_if_gnt     = !rst && if_req && !w_d_gnt;
    assign if_gnt       = w_if_gnt;
    assign d_gnt        = w_d_gnt;

    assign w_if_err = (if_addr[1:0] != 2'b00) || (|if_addr[31:ADDR_W+2]);
    assign w_d_err  = w_d_mis || (|d_addr[31:ADDR_W+2]);

    // Alignment rule per access size; size 3 is always an error.
    always_comb begin
        case (d_size)
            BYTE:    w_d_mis = 1'b0;
            HALF:    w_d_mis = d_addr[0];
            WORD:    w_d_mis = (d_addr[1:0] != 2'b00);
            default: w_d_mis = 1'b1;
        endcase
    end

    assign ram_addr = w_d_gnt  ? d_addr  :
                      w_if_gnt ? if_addr : 32'h0000_0000;

    // Response register and data-streak counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= 4'd0;
            r_valid  <= 1'b0;
            r_rsp    <= '0;
        end else begin
            r_valid <= w_if_gnt || w_d_gnt;
            if (w_d_gnt) begin
                r_rsp <= '{OWN_D, d_we, d_size, d_unsigned, d_addr[1:0], d_wdata, w_d_err};
            end else if (w_if_gnt) begin
                r_rsp <= '{OWN_IF, 1'b0, WORD, 1'b0, 2'b00, 32'h0000_0000, w_if_err};
            end else begin
                r_rsp <= r_rsp;
            end
            if (!if_req || w_if_gnt) begin
                r_streak <= 4'd0;
            end else if (w_d_gnt && (r_streak != 4'(MAX_DSTREAK))) begin
                r_streak <= r_streak + 4'd1;
            end else begin
                r_streak <= r_streak;
            end
        end
    end

    mem_lane_merge u_lane (
        .i_size   (r_rsp.size),
        .i_uns    (r_rsp.uns),
        .i_off    (r_rsp.off),
        .i_wdata  (r_rsp.wdata),
        .i_rdata  (ram_rdata),
        .o_merged (w_merged),
        .o_load   (w_load)
    );

    // Reset masks the response stage so a registered store cannot leak out.
    assign w_live     = !rst && r_valid;
    assign if_rvalid  = w_live && (r_rsp.owner == OWN_IF);
    assign if_err     = if_rvalid && r_rsp.err;
    assign if_rdata   = (if_rvalid && !r_rsp.err) ? ram_rdata : 32'h0000_0000;
    assign d_rvalid   = w_live && (r_rsp.owner == OWN_D);
    assign d_err      = d_rvalid && r_rsp.err;
    assign d_rdata    = (d_rvalid && !r_rsp.err && !r_rsp.we) ? w_load : 32'h0000_0000;
    assign w_store    = d_rvalid && !r_rsp.err && r_rsp.we;
    assign ram_mem_op = w_store ? MEM_STORE : MEM_LOAD;
    assign ram_wdata  = w_store ? w_merged : 32'h0000_0000;

endmodule
